tile_route_dispatcher: RTL and testbench

Downstream partner of the SAD workload allocator. Captures the same continuous tiled 8-bit pixel stream into a ring of tile slots and waits for the allocator's per-tile decision. Once the decision arrives, replays the tile in order on either the CNN port or the bypass (light-path) port, using a valid/ready handshake. Sits between the pixel source and the two compute back-ends.

---
 rtl/tile_route_dispatcher_if.sv | 34 +++
 rtl/tile_route_dispatcher.sv | 247 ++++++++++++++++++++++++
 tb/tb_tile_route_dispatcher.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tile_route_dispatcher_if.sv
// Pixel-in / two-port-out bus of the tile route dispatcher.
// master drives pixels, decisions and readies; slave is the dispatcher.
interface tile_route_dispatcher_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int FREE_W = $clog2(NUM_SLOTS) + 1;

  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              route_to_cnn;
  logic              decision_valid;
  logic [7:0]        cnn_data;
  logic              cnn_valid;
  logic              cnn_last;
  logic              cnn_ready;
  logic [7:0]        byp_data;
  logic              byp_valid;
  logic              byp_last;
  logic              byp_ready;
  logic [15:0]       drop_count;
  logic [FREE_W-1:0] free_slots;

  modport master (
    output pix_data, pix_valid, route_to_cnn, decision_valid, cnn_ready, byp_ready,
    input  cnn_data, cnn_valid, cnn_last, byp_data, byp_valid, byp_last,
    input  drop_count, free_slots
  );

  modport slave (
    input  pix_data, pix_valid, route_to_cnn, decision_valid, cnn_ready, byp_ready,
    output cnn_data, cnn_valid, cnn_last, byp_data, byp_valid, byp_last,
    output drop_count, free_slots
  );
endinterface

// File: rtl/tile_route_dispatcher.sv
// Buffers a tiled pixel stream in a ring of slots and replays each tile, in
// arrival order, on the CNN or bypass port once its route decision arrives.
module tile_route_dispatcher #(
  parameter int TILE_WIDTH     = 16,
  parameter int NUM_SLOTS      = 4,
  parameter int SKIP_DECISIONS = 1
) (
  input logic iClk,
  input logic iRst,
  tile_route_dispatcher_if.slave bus
);
  localparam int TILE_PIXELS = TILE_WIDTH * TILE_WIDTH;
  localparam int IDX_W       = (TILE_PIXELS > 1) ? $clog2(TILE_PIXELS) : 1;
  localparam int PTR_W       = $clog2(NUM_SLOTS);
  localparam int ADDR_W      = PTR_W + IDX_W;
  localparam int FREE_W      = PTR_W + 1;
  localparam int FIFO_DEPTH  = NUM_SLOTS + 2;
  localparam int FP_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int SKIP_W      = (SKIP_DECISIONS > 0) ? $clog2(SKIP_DECISIONS + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TILE_PIXELS - 1);
  localparam logic             SINGLE_PIX = (TILE_PIXELS == 1);

  typedef enum logic [2:0] {S_FREE, S_FILLING, S_WAIT_DEC, S_READY, S_DRAINING} slot_state_t;
  typedef enum logic {D_IDLE, D_BUSY} drain_state_t;

  slot_state_t             slot_state_reg [NUM_SLOTS];
  slot_state_t             slot_state_next[NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    slot_route_reg, slot_route_next;
  logic [NUM_SLOTS-1:0]    slot_free_next;
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [IDX_W-1:0]        wr_idx_reg, wr_idx_next;
  logic                    wr_keep_reg, wr_keep_next;
  logic [FIFO_DEPTH-1:0]   fifo_mem_reg, fifo_mem_next;
  logic [FP_W-1:0]         fifo_wr_reg, fifo_wr_next;
  logic [FP_W-1:0]         fifo_rd_reg, fifo_rd_next;
  logic [CNT_W-1:0]        fifo_cnt_reg, fifo_cnt_next;
  logic [PTR_W-1:0]        dec_ptr_reg, dec_ptr_next;
  logic [SKIP_W-1:0]       skip_cnt_reg, skip_cnt_next;
  logic                    proto_err_reg, proto_err_next;
  drain_state_t            drain_state_reg, drain_state_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [IDX_W-1:0]        rd_idx_reg, rd_idx_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    out_last_reg, out_last_next;
  logic                    out_cnn_reg, out_cnn_next;
  logic [7:0]              out_data_reg;
  logic [15:0]             drop_count_reg, drop_count_next;
  logic [FREE_W-1:0]       free_slots_reg, free_slots_next;

  logic [7:0]              mem [NUM_SLOTS*TILE_PIXELS];
  logic                    mem_we, rd_en, keep_cur, push, push_ok, pop, ready_sel;
  logic [ADDR_W-1:0]       wr_addr, rd_addr;
  logic [IDX_W-1:0]        rd_idx_inc;

  function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_sel  = out_cnn_reg ? bus.cnn_ready : bus.byp_ready;
  assign rd_idx_inc = rd_idx_reg + 1'b1;

  always_comb begin
    slot_state_next  = slot_state_reg;
    slot_route_next  = slot_route_reg;
    wr_ptr_next      = wr_ptr_reg;
    wr_idx_next      = wr_idx_reg;
    wr_keep_next     = wr_keep_reg;
    fifo_mem_next    = fifo_mem_reg;
    fifo_wr_next     = fifo_wr_reg;
    fifo_rd_next     = fifo_rd_reg;
    fifo_cnt_next    = fifo_cnt_reg;
    dec_ptr_next     = dec_ptr_reg;
    skip_cnt_next    = skip_cnt_reg;
    proto_err_next   = proto_err_reg;
    drain_state_next = drain_state_reg;
    rd_ptr_next      = rd_ptr_reg;
    rd_idx_next      = rd_idx_reg;
    out_valid_next   = out_valid_reg;
    out_last_next    = out_last_reg;
    out_cnn_next     = out_cnn_reg;
    drop_count_next  = drop_count_reg;
    mem_we           = 1'b0;
    rd_en            = 1'b0;
    wr_addr          = {wr_ptr_reg, wr_idx_reg};
    rd_addr          = {rd_ptr_reg, rd_idx_reg};
    keep_cur         = wr_keep_reg;
    push             = 1'b0;
    push_ok          = 1'b0;
    pop              = 1'b0;

    // Write side: the keep/drop verdict is taken on pixel 0 and held for the tile.
    if (bus.pix_valid) begin
      if (wr_idx_reg == '0) begin
        keep_cur     = (slot_state_reg[wr_ptr_reg] == S_FREE);
        wr_keep_next = keep_cur;
        if (keep_cur) slot_state_next[wr_ptr_reg] = S_FILLING;
      end
      mem_we = keep_cur;
      if (wr_idx_reg == IDX_LAST) begin
        push        = 1'b1;
        wr_idx_next = '0;
        if (keep_cur) begin
          slot_state_next[wr_ptr_reg] = S_WAIT_DEC;
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end else if (drop_count_reg != 16'hFFFF) begin
          drop_count_next = drop_count_reg + 16'd1;
        end
      end else begin
        wr_idx_next = wr_idx_reg + 1'b1;
      end
    end

    // Decision side; evaluated after the write side so READY wins a same-slot race.
    if (bus.decision_valid) begin
      if (skip_cnt_reg != '0) begin
        skip_cnt_next = skip_cnt_reg - 1'b1;
      end else if (fifo_cnt_reg == '0) begin
        proto_err_next = 1'b1;
      end else begin
        pop = 1'b1;
        if (fifo_mem_reg[fifo_rd_reg]) begin
          slot_state_next[dec_ptr_reg] = S_READY;
          slot_route_next[dec_ptr_reg] = bus.route_to_cnn;
          dec_ptr_next = dec_ptr_reg + 1'b1;
        end
      end
    end

    if (pop) fifo_rd_next = fifo_inc(fifo_rd_reg);
    if (push && (fifo_cnt_reg != CNT_W'(FIFO_DEPTH) || pop)) begin
      push_ok = 1'b1;
      fifo_mem_next[fifo_wr_reg] = keep_cur;
      fifo_wr_next = fifo_inc(fifo_wr_reg);
    end
    case ({push_ok, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase

    // Drain side: the output register doubles as the memory read register.
    unique case (drain_state_reg)
      D_IDLE: begin
        if (slot_state_reg[rd_ptr_reg] == S_READY) begin
          slot_state_next[rd_ptr_reg] = S_DRAINING;
          drain_state_next = D_BUSY;
          rd_en            = 1'b1;
          rd_addr          = {rd_ptr_reg, {IDX_W{1'b0}}};
          rd_idx_next      = '0;
          out_valid_next   = 1'b1;
          out_last_next    = SINGLE_PIX;
          out_cnn_next     = slot_route_reg[rd_ptr_reg];
        end
      end
      D_BUSY: begin
        if (out_valid_reg && ready_sel) begin
          if (out_last_reg) begin
            slot_state_next[rd_ptr_reg] = S_FREE;
            rd_ptr_next      = rd_ptr_reg + 1'b1;
            out_valid_next   = 1'b0;
            out_last_next    = 1'b0;
            drain_state_next = D_IDLE;
          end else begin
            rd_en         = 1'b1;
            rd_addr       = {rd_ptr_reg, rd_idx_inc};
            rd_idx_next   = rd_idx_inc;
            out_last_next = (rd_idx_inc == IDX_LAST);
          end
        end
      end
      default: drain_state_next = D_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_free
      assign slot_free_next[gi] = (slot_state_next[gi] == S_FREE);
    end
  endgenerate
  assign free_slots_next = FREE_W'($countones(slot_free_next));

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_state_reg[i] <= S_FREE;
      slot_route_reg  <= '0;
      wr_ptr_reg      <= '0;
      wr_idx_reg      <= '0;
      wr_keep_reg     <= 1'b0;
      fifo_mem_reg    <= '0;
      fifo_wr_reg     <= '0;
      fifo_rd_reg     <= '0;
      fifo_cnt_reg    <= '0;
      dec_ptr_reg     <= '0;
      skip_cnt_reg    <= SKIP_W'(SKIP_DECISIONS);
      proto_err_reg   <= 1'b0;
      drain_state_reg <= D_IDLE;
      rd_ptr_reg      <= '0;
      rd_idx_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      out_cnn_reg     <= 1'b0;
      drop_count_reg  <= '0;
      free_slots_reg  <= FREE_W'(NUM_SLOTS);
    end else begin
      slot_state_reg  <= slot_state_next;
      slot_route_reg  <= slot_route_next;
      wr_ptr_reg      <= wr_ptr_next;
      wr_idx_reg      <= wr_idx_next;
      wr_keep_reg     <= wr_keep_next;
      fifo_mem_reg    <= fifo_mem_next;
      fifo_wr_reg     <= fifo_wr_next;
      fifo_rd_reg     <= fifo_rd_next;
      fifo_cnt_reg    <= fifo_cnt_next;
      dec_ptr_reg     <= dec_ptr_next;
      skip_cnt_reg    <= skip_cnt_next;
      proto_err_reg   <= proto_err_next;
      drain_state_reg <= drain_state_next;
      rd_ptr_reg      <= rd_ptr_next;
      rd_idx_reg      <= rd_idx_next;
      out_valid_reg   <= out_valid_next;
      out_last_reg    <= out_last_next;
      out_cnn_reg     <= out_cnn_next;
      drop_count_reg  <= drop_count_next;
      free_slots_reg  <= free_slots_next;
    end
  end

  always_ff @(posedge iClk) begin
    if (mem_we) mem[wr_addr] <= bus.pix_data;
  end

  always_ff @(posedge iClk) begin
    if (!iRst)      out_data_reg <= '0;
    else if (rd_en) out_data_reg <= mem[rd_addr];
  end

  assign bus.cnn_valid  = out_valid_reg & out_cnn_reg;
  assign bus.cnn_last   = out_last_reg & out_cnn_reg;
  assign bus.cnn_data   = out_cnn_reg ? out_data_reg : 8'h00;
  assign bus.byp_valid  = out_valid_reg & ~out_cnn_reg;
  assign bus.byp_last   = out_last_reg & ~out_cnn_reg;
  assign bus.byp_data   = out_cnn_reg ? 8'h00 : out_data_reg;
  assign bus.drop_count = drop_count_reg;
  assign bus.free_slots = free_slots_reg;
endmodule

// File: tb/tb_tile_route_dispatcher.sv
// Directed bench: streams tiles, issues decisions and checks every drained
// pixel against a scoreboard filled from the decisions the bench itself issues.
module tb_tile_route_dispatcher;
  localparam int TP = 256;

  typedef struct packed {
    logic       cnn;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_route_dispatcher_if #(.NUM_SLOTS(4)) bus ();

  tile_route_dispatcher #(.TILE_WIDTH(16), .NUM_SLOTS(4), .SKIP_DECISIONS(1)) dut (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  exp_t exp_q[$];
  logic rand_rdy = 1'b0, cnn_rdy_cfg = 1'b1, byp_rdy_cfg = 1'b1;
  logic hold_on = 1'b0, hold_cnn = 1'b0, hold_last = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic cont_on = 1'b0, cont_cnn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_tile(input logic [7:0] seed, input logic rt);
    exp_t e;
    for (int i = 0; i < TP; i++) begin
      e.cnn = rt; e.data = 8'(seed + i); e.last = (i == TP - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive inputs, score any handshake about to happen, advance.
  task automatic step(input logic pv, input logic [7:0] pd, input logic dv, input logic rt);
    logic cr, br, c, v, l;
    logic [7:0] d;
    exp_t e;
    cr = rand_rdy ? 1'($urandom_range(0, 1)) : cnn_rdy_cfg;
    br = rand_rdy ? 1'($urandom_range(0, 1)) : byp_rdy_cfg;
    bus.pix_valid = pv; bus.pix_data = pd;
    bus.decision_valid = dv; bus.route_to_cnn = rt;
    bus.cnn_ready = cr; bus.byp_ready = br;
    c = bus.cnn_valid;
    v = bus.cnn_valid | bus.byp_valid;
    d = c ? bus.cnn_data : bus.byp_data;
    l = c ? bus.cnn_last : bus.byp_last;
    if (hold_on) begin
      check("stall_valid", 32'({v, c}), 32'({1'b1, hold_cnn}));
      check("stall_data", 32'({d, l}), 32'({hold_data, hold_last}));
    end
    if (cont_on) check("no_gap_valid", 32'({v, c}), 32'({1'b1, cont_cnn}));
    hold_on = 1'b0;
    cont_on = 1'b0;
    if (v) begin
      check("port_excl", 32'(bus.cnn_valid & bus.byp_valid), 32'd0);
      if ((c && cr) || (!c && br)) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(v), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("xfer", 32'({c, d, l}), 32'({e.cnn, e.data, e.last}));
        end
        cont_on = !l; cont_cnn = c;
      end else begin
        hold_on = 1'b1; hold_cnn = c; hold_data = d; hold_last = l;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input logic [7:0] seed, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(1'b1, 8'(seed + i), 1'b0, 1'b0);
  endtask

  task automatic tile_end(input logic [7:0] seed, input logic dv, input logic rt);
    step(1'b1, 8'(seed + TP - 1), dv, rt);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    bus.pix_valid = 1'b0; bus.pix_data = 8'h00;
    bus.decision_valid = 1'b0; bus.route_to_cnn = 1'b0;
    bus.cnn_ready = 1'b0; bus.byp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hold_on = 1'b0;
    cont_on = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_valids"}, 32'({bus.cnn_valid, bus.byp_valid, bus.cnn_last, bus.byp_last}), 32'd0);
    check({tag, "_free"}, 32'(bus.free_slots), 32'd4);
    check({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
    check({tag, "_proto"}, 32'(dut.proto_err_reg), 32'd0);
  endtask

  initial begin
    logic [7:0] s;
    int n;

    // Reset state.
    do_reset(3);
    check_idle_reset("reset");
    check("reset_data", 32'({bus.cnn_data, bus.byp_data}), 32'd0);

    // Three tiles, routes 1,0,1; latency; simultaneous last-write/decision/last-handshake.
    cnn_rdy_cfg = 1'b1; byp_rdy_cfg = 1'b1; rand_rdy = 1'b0;
    stream(8'h00, 0, TP - 2); tile_end(8'h00, 1'b1, 1'b1);
    stream(8'h40, 0, TP - 2); tile_end(8'h40, 1'b1, 1'b1);
    push_tile(8'h00, 1'b1);
    check("lat_pre_valid", 32'(bus.cnn_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lat_post", 32'({bus.cnn_valid, bus.cnn_data, bus.cnn_last}), 32'({1'b1, 8'h00, 1'b0}));
    stream(8'h80, 0, TP - 2);
    check("sim_pre_last", 32'({bus.cnn_valid, bus.cnn_last, bus.cnn_data}), 32'({1'b1, 1'b1, 8'hFF}));
    check("sim_pre_free", 32'(bus.free_slots), 32'd1);
    tile_end(8'h80, 1'b1, 1'b0);
    push_tile(8'h40, 1'b0);
    check("sim_post_free", 32'(bus.free_slots), 32'd2);
    check("sim_post_drop", 32'(bus.drop_count), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    push_tile(8'h80, 1'b1);
    drain(3000);
    check("ramp_end_free", 32'(bus.free_slots), 32'd4);

    // Random readies on both ports, mixed routes.
    do_reset(2);
    rand_rdy = 1'b1;
    stream(8'h11, 0, TP - 2); tile_end(8'h11, 1'b1, 1'b0);
    stream(8'h52, 0, TP - 2); tile_end(8'h52, 1'b1, 1'b0);
    push_tile(8'h11, 1'b0);
    stream(8'h93, 0, TP - 2); tile_end(8'h93, 1'b1, 1'b1);
    push_tile(8'h52, 1'b1);
    stream(8'hD4, 0, TP - 2); tile_end(8'hD4, 1'b1, 1'b1);
    push_tile(8'h93, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    push_tile(8'hD4, 1'b0);
    drain(6000);
    check("rand_free", 32'(bus.free_slots), 32'd4);
    check("rand_drop", 32'(bus.drop_count), 32'd0);

    // CNN stalled: six tiles into four slots, tiles 4 and 5 dropped.
    do_reset(2);
    rand_rdy = 1'b0; cnn_rdy_cfg = 1'b0; byp_rdy_cfg = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s = 8'(k * 16 + 3);
      stream(s, 0, TP - 2);
      tile_end(s, 1'b1, 1'b1);
      if (k >= 1 && k <= 4) push_tile(8'((k - 1) * 16 + 3), 1'b1);
      if (k == 4) check("drop_after_t4", 32'(bus.drop_count), 32'd1);
    end
    check("drop_after_t5", 32'(bus.drop_count), 32'd2);
    check("drop_full", 32'(bus.free_slots), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("drop_no_proto", 32'(dut.proto_err_reg), 32'd0);
    cnn_rdy_cfg = 1'b1;
    drain(3000);
    check("drop_end_free", 32'(bus.free_slots), 32'd4);
    check("drop_end_cnt", 32'(bus.drop_count), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("proto_err", 32'(dut.proto_err_reg), 32'd1);

    // Reset while pixel 100 of a CNN tile is on the port.
    stream(8'h5A, 0, TP - 1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    push_tile(8'h5A, 1'b1);
    xfer_cnt = 0;
    n = 0;
    while (xfer_cnt < 100 && n < 1000) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("pre_rst_px", 32'({bus.cnn_valid, bus.cnn_data}), 32'({1'b1, 8'(8'h5A + 100)}));
    do_reset(1);
    check_idle_reset("mid_rst");
    stream(8'hA7, 0, TP - 2); tile_end(8'hA7, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    push_tile(8'hA7, 1'b0);
    drain(3000);
    check("post_rst_free", 32'(bus.free_slots), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
